// File: rtl/game_flow_if.sv
// Control/status bundle between the game sequencer and the rest of the Pac-Man datapath.
// The slave side is the sequencer; the master side drives frame ticks, keys and collision flags.
interface game_flow_if;
    logic       tick;
    logic       start;
    logic       crash;
    logic       all_eaten;
    logic       eat_pulse;
    logic       run;
    logic       actor_rst_n;
    logic       map_reload;
    logic [1:0] lives;
    logic [3:0] level;
    logic [2:0] state;
    logic       over;
    logic       beep;

    modport master (
        output tick, start, crash, all_eaten, eat_pulse,
        input  run, actor_rst_n, map_reload, lives, level, state, over, beep
    );

    modport slave (
        input  tick, start, crash, all_eaten, eat_pulse,
        output run, actor_rst_n, map_reload, lives, level, state, over, beep
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game phase sequencer: attract, ready countdown, play, death, level clear, game over.
// Every output is a flop; an input sampled at an edge takes effect on that same edge.
module game_flow_ctrl #(
    parameter int LIVES       = 3,
    parameter int READY_TICKS = 120,
    parameter int DEATH_TICKS = 90,
    parameter int CLEAR_TICKS = 120,
    parameter int BEEP_TICKS  = 6
) (
    input  logic        clk,
    input  logic        rst,
    game_flow_if.slave  bus
);

    localparam int MAX_RD    = (READY_TICKS > DEATH_TICKS) ? READY_TICKS : DEATH_TICKS;
    localparam int MAX_TICKS = (MAX_RD > CLEAR_TICKS) ? MAX_RD : CLEAR_TICKS;
    localparam int CW_RAW    = $clog2(MAX_TICKS);
    // At least four bits so the CLEAR blink bit always exists.
    localparam int CW        = (CW_RAW < 4) ? 4 : CW_RAW;
    localparam int BW        = $clog2(BEEP_TICKS + 1);

    localparam logic [CW-1:0] READY_LOAD = CW'(READY_TICKS - 1);
    localparam logic [CW-1:0] DEATH_LOAD = CW'(DEATH_TICKS - 1);
    localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_TICKS - 1);
    localparam logic [BW-1:0] BEEP_LOAD  = BW'(BEEP_TICKS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READY = 3'd1,
        S_PLAY  = 3'd2,
        S_DYING = 3'd3,
        S_CLEAR = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    state_t        state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [BW-1:0] beep_cnt_q, beep_cnt_n;
    logic [1:0]    lives_q, lives_n;
    logic [3:0]    level_q, level_n;
    logic          run_q, run_n;
    logic          over_q, over_n;
    logic          restart_n_q, restart_n_n;
    logic          reload_q, reload_n;
    logic          beep_q, beep_n;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            beep_cnt_q  <= '0;
            lives_q     <= 2'(LIVES);
            level_q     <= '0;
            run_q       <= 1'b0;
            over_q      <= 1'b0;
            restart_n_q <= 1'b1;
            reload_q    <= 1'b0;
            beep_q      <= 1'b0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            beep_cnt_q  <= beep_cnt_n;
            lives_q     <= lives_n;
            level_q     <= level_n;
            run_q       <= run_n;
            over_q      <= over_n;
            restart_n_q <= restart_n_n;
            reload_q    <= reload_n;
            beep_q      <= beep_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        beep_cnt_n  = beep_cnt_q;
        lives_n     = lives_q;
        level_n     = level_q;
        restart_n_n = 1'b1;
        reload_n    = 1'b0;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (bus.start) begin
                    state_n     = S_READY;
                    cnt_n       = READY_LOAD;
                    lives_n     = 2'(LIVES);
                    level_n     = '0;
                    restart_n_n = 1'b0;
                    reload_n    = 1'b1;
                end
            end
            S_READY: begin
                if (bus.tick) begin
                    if (cnt_q == '0) state_n = S_PLAY;
                    else             cnt_n   = cnt_q - CW'(1);
                end
            end
            S_PLAY: begin
                if (bus.crash) begin
                    state_n    = S_DYING;
                    cnt_n      = DEATH_LOAD;
                    beep_cnt_n = '0;
                end else if (bus.all_eaten) begin
                    state_n    = S_CLEAR;
                    cnt_n      = CLEAR_LOAD;
                    beep_cnt_n = '0;
                end else if (bus.eat_pulse) begin
                    beep_cnt_n = BEEP_LOAD;
                end else if (bus.tick && beep_cnt_q != '0) begin
                    beep_cnt_n = beep_cnt_q - BW'(1);
                end
            end
            S_DYING: begin
                if (bus.tick) begin
                    if (cnt_q != '0) begin
                        cnt_n = cnt_q - CW'(1);
                    end else if (lives_q == 2'd1) begin
                        lives_n = 2'd0;
                        state_n = S_OVER;
                    end else begin
                        // Beans survive a death, so only the actors restart.
                        lives_n     = lives_q - 2'd1;
                        state_n     = S_READY;
                        cnt_n       = READY_LOAD;
                        restart_n_n = 1'b0;
                    end
                end
            end
            S_CLEAR: begin
                if (bus.tick) begin
                    if (cnt_q != '0) begin
                        cnt_n = cnt_q - CW'(1);
                    end else begin
                        level_n     = (level_q == 4'hF) ? level_q : level_q + 4'd1;
                        state_n     = S_READY;
                        cnt_n       = READY_LOAD;
                        restart_n_n = 1'b0;
                        reload_n    = 1'b1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        run_n  = (state_n == S_PLAY);
        over_n = (state_n == S_OVER);
        case (state_n)
            S_DYING: beep_n = 1'b1;
            S_CLEAR: beep_n = cnt_n[3];
            S_PLAY:  beep_n = (beep_cnt_n != '0);
            default: beep_n = 1'b0;
        endcase
    end

    assign bus.state       = state_q;
    assign bus.run         = run_q;
    assign bus.over        = over_q;
    assign bus.lives       = lives_q;
    assign bus.level       = level_q;
    assign bus.actor_rst_n = restart_n_q;
    assign bus.map_reload  = reload_q;
    assign bus.beep        = beep_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with a tick-level reference model checked every cycle.
module tb_game_flow_ctrl;
    localparam int P_LIVES = 3;
    localparam int P_READY = 3;
    localparam int P_DEATH = 2;
    localparam int P_CLEAR = 16;
    localparam int P_BEEP  = 2;

    logic clk;
    logic rst;
    game_flow_if gif();

    game_flow_ctrl #(
        .LIVES(P_LIVES), .READY_TICKS(P_READY), .DEATH_TICKS(P_DEATH),
        .CLEAR_TICKS(P_CLEAR), .BEEP_TICKS(P_BEEP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(gif)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: phase tracked as ticks remaining, eat beep as ticks remaining.
    int m_state = 0;
    int m_left = 0;
    int m_eat = 0;
    int m_lives = P_LIVES;
    int m_level = 0;
    bit m_reload = 0;
    bit m_restart = 0;
    bit m_on = 0;
    int tick_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_beep();
        case (m_state)
            3:       return 1'b1;
            4:       return ((m_left - 1) & 8) != 0;
            2:       return m_eat > 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic enter_ready();
        m_state = 1;
        m_left = P_READY;
        m_restart = 1;
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        gif.tick = 0;
        forever begin
            repeat (3) @(posedge clk);
            #1 gif.tick = 1;
            @(posedge clk);
            #1 gif.tick = 0;
        end
    end

    always @(posedge clk) begin
        if (gif.tick) tick_seen++;
        if (!rst) begin
            m_state = 0; m_left = 0; m_eat = 0; m_lives = P_LIVES; m_level = 0;
            m_reload = 0; m_restart = 0; m_on = 1;
        end else begin
            m_reload = 0;
            m_restart = 0;
            case (m_state)
                0, 5: if (gif.start) begin
                    m_lives = P_LIVES; m_level = 0; m_reload = 1; enter_ready();
                end
                1: if (gif.tick) begin
                    m_left--;
                    if (m_left == 0) m_state = 2;
                end
                2: begin
                    if (gif.crash) begin
                        m_state = 3; m_left = P_DEATH; m_eat = 0;
                    end else if (gif.all_eaten) begin
                        m_state = 4; m_left = P_CLEAR; m_eat = 0;
                    end else if (gif.eat_pulse) m_eat = P_BEEP;
                    else if (gif.tick && m_eat > 0) m_eat--;
                end
                3: if (gif.tick) begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_lives == 1) begin m_lives = 0; m_state = 5; end
                        else begin m_lives--; enter_ready(); end
                    end
                end
                4: if (gif.tick) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_level = (m_level >= 15) ? 15 : m_level + 1;
                        m_reload = 1;
                        enter_ready();
                    end
                end
                default: m_state = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("m_state", gif.state, m_state);
            chk("m_run", gif.run, m_state == 2);
            chk("m_over", gif.over, m_state == 5);
            chk("m_lives", gif.lives, m_lives);
            chk("m_level", gif.level, m_level);
            chk("m_map_reload", gif.map_reload, m_reload);
            chk("m_actor_rst_n", gif.actor_rst_n, !m_restart);
            chk("m_beep", gif.beep, model_beep());
        end
    end

    task automatic wait_state(input int target, input string name);
        bit hit = 0;
        for (int i = 0; i < 300 && !hit; i++) begin
            if (m_state == target) hit = 1;
            else @(negedge clk);
        end
        if (!hit) chk({"timeout_", name}, m_state, target);
    endtask

    task automatic wait_ticks(input int n);
        int target = tick_seen + n;
        for (int i = 0; i < 40 * n && tick_seen < target; i++) @(negedge clk);
        if (tick_seen < target) chk("timeout_ticks", tick_seen, target);
    endtask

    task automatic pulse(input int which);
        @(posedge clk);
        #1;
        case (which)
            0: gif.start = 1;
            1: gif.crash = 1;
            2: gif.all_eaten = 1;
            3: gif.eat_pulse = 1;
            default: begin gif.crash = 1; gif.all_eaten = 1; end
        endcase
        @(posedge clk);
        #1;
        gif.start = 0; gif.crash = 0; gif.all_eaten = 0; gif.eat_pulse = 0;
        @(negedge clk);
    endtask

    initial begin
        int t0;
        rst = 0;
        gif.start = 0; gif.crash = 0; gif.all_eaten = 0; gif.eat_pulse = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state", gif.state, 0);
        chk("rst_lives", gif.lives, 3);
        chk("rst_actor_rst_n", gif.actor_rst_n, 1);
        chk("rst_beep", gif.beep, 0);
        rst = 1;

        // 1: start from IDLE
        pulse(0);
        t0 = tick_seen;
        chk("t1_state", gif.state, 1);
        chk("t1_lives", gif.lives, 3);
        chk("t1_map_reload", gif.map_reload, 1);
        chk("t1_actor_rst_n", gif.actor_rst_n, 0);
        @(negedge clk);
        chk("t1_reload_1clk", gif.map_reload, 0);
        chk("t1_restart_1clk", gif.actor_rst_n, 1);
        wait_state(2, "t1_play");
        chk("t1_ready_ticks", tick_seen - t0, 3);
        chk("t1_run", gif.run, 1);

        // 2: first death
        pulse(1);
        t0 = tick_seen;
        chk("t2_state", gif.state, 3);
        chk("t2_run", gif.run, 0);
        chk("t2_beep", gif.beep, 1);
        wait_state(1, "t2_ready");
        chk("t2_death_ticks", tick_seen - t0, 2);
        chk("t2_lives", gif.lives, 2);
        chk("t2_actor_rst_n", gif.actor_rst_n, 0);
        chk("t2_map_reload", gif.map_reload, 0);

        // 3: two more deaths end the game, start restarts it
        wait_state(2, "t3_play_a");
        pulse(1);
        wait_state(1, "t3_ready");
        chk("t3_lives1", gif.lives, 1);
        wait_state(2, "t3_play_b");
        pulse(1);
        wait_state(5, "t3_over");
        chk("t3_state", gif.state, 5);
        chk("t3_over", gif.over, 1);
        chk("t3_lives0", gif.lives, 0);
        pulse(0);
        chk("t3_restart_state", gif.state, 1);
        chk("t3_restart_lives", gif.lives, 3);
        chk("t3_restart_level", gif.level, 0);
        chk("t3_restart_reload", gif.map_reload, 1);

        // 4: crash beats all_eaten
        wait_state(2, "t4_play");
        pulse(4);
        chk("t4_state", gif.state, 3);
        wait_state(1, "t4_ready");
        wait_state(2, "t4_play_again");

        // 5: level clear with blinking beep
        pulse(2);
        t0 = tick_seen;
        chk("t5_state", gif.state, 4);
        chk("t5_beep_start", gif.beep, 1);
        wait_ticks(7);
        chk("t5_beep_7", gif.beep, 1);
        wait_ticks(1);
        chk("t5_beep_8", gif.beep, 0);
        wait_state(1, "t5_ready");
        chk("t5_clear_ticks", tick_seen - t0, 16);
        chk("t5_level", gif.level, 1);
        chk("t5_reload", gif.map_reload, 1);
        chk("t5_actor_rst_n", gif.actor_rst_n, 0);

        // 6: eat beeps, retrigger, dropped eat, reset mid-death
        wait_state(2, "t6_play");
        pulse(3);
        chk("t6_eat_on", gif.beep, 1);
        wait_ticks(1);
        chk("t6_eat_t1", gif.beep, 1);
        wait_ticks(1);
        chk("t6_eat_t2", gif.beep, 0);
        pulse(3);
        wait_ticks(1);
        chk("t6_retrig_pre", gif.beep, 1);
        pulse(3);
        wait_ticks(1);
        chk("t6_retrig_t1", gif.beep, 1);
        wait_ticks(1);
        chk("t6_retrig_t2", gif.beep, 0);
        pulse(1);
        wait_state(1, "t6_ready");
        pulse(3);
        chk("t6_ready_eat", gif.beep, 0);
        wait_state(2, "t6_play_b");
        chk("t6_play_no_leak", gif.beep, 0);
        pulse(1);
        chk("t6_dying", gif.state, 3);
        rst = 0;
        @(posedge clk);
        @(negedge clk);
        chk("t6_rst_state", gif.state, 0);
        chk("t6_rst_beep", gif.beep, 0);
        chk("t6_rst_lives", gif.lives, 3);
        chk("t6_rst_level", gif.level, 0);
        rst = 1;
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end
endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Top-level game sequencer for the Pac-Man datapath. It steps the game through attract, ready countdown, play, death, level-clear and game-over phases. It gates movement of the Pac-Man and ghost actors, restarts actor positions, and requests bean-map reloads. It also owns the lives and level counters and arbitrates the single buzzer output between death, level-clear and bean-eaten sound requests.

Parameters:
LIVES, 3, lives loaded at game start (1..3).
READY_TICKS, 120, tick count of the READY countdown.
DEATH_TICKS, 90, tick count of the DYING phase.
CLEAR_TICKS, 120, tick count of the CLEAR phase.
BEEP_TICKS, 6, tick length of one eat beep.

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-low
tick  in  1  one-clk pulse per frame (~60 Hz), from clock divider
start  in  1  one-clk pulse, start/restart request (debounced key)
crash  in  1  level, Pac-Man/ghost collision detected
all_eaten  in  1  level, bean map empty
eat_pulse  in  1  one-clk pulse, bean eaten
run  out  1  actor movement enable
actor_rst_n  out  1  active-low one-clk restart pulse to Pac-Man/ghost position logic
map_reload  out  1  one-clk pulse, reload bean map and score
lives  out  2  remaining lives
level  out  4  current level, from 0
state  out  3  IDLE=0 READY=1 PLAY=2 DYING=3 CLEAR=4 OVER=5
over  out  1  high while in OVER
beep  out  1  buzzer enable

Behaviour:
- rst low at a clk edge sets: state=IDLE, lives=LIVES, level=0, run=0, actor_rst_n=1, map_reload=0, beep=0, over=0, all counters cleared. A mid-operation reset aborts the current phase immediately.
- All outputs are registered. A qualifying input sampled at edge N changes state and outputs at edge N.
- run=1 iff state==PLAY. over=1 iff state==OVER.
- Phase counter: loaded on entry to READY, DYING or CLEAR with the matching *_TICKS-1. It decrements only on tick. The phase exits on the tick edge where counter==0, so each phase lasts exactly *_TICKS ticks.
- IDLE: on start, go to READY. Load lives=LIVES and level=0. Pulse map_reload and actor_rst_n.
- READY: when the count expires, go to PLAY. crash, all_eaten and eat_pulse are ignored.
- PLAY:
  - crash=1 goes to DYING.
  - Otherwise all_eaten=1 goes to CLEAR.
  - If crash and all_eaten are high in the same cycle, crash wins.
  - start is ignored.
- DYING: when the count expires:
  - if lives==1, set lives=0 and go to OVER;
  - else decrement lives, go to READY and pulse actor_rst_n only. Beans are preserved, so map_reload is not pulsed.
- CLEAR: when the count expires, set level=level+1 (saturating at 15), go to READY, and pulse both map_reload and actor_rst_n.
- OVER: hold until start, then behave exactly as start in IDLE.
- start in READY, PLAY, DYING or CLEAR is ignored.
- actor_rst_n and map_reload are low/high for exactly one clk, coincident with the first cycle of READY.
- Beep arbitration, fixed priority:
  1. DYING: beep=1 for the whole state.
  2. CLEAR: beep = phase counter bit 3 (blink).
  3. Eat: eat_pulse while in PLAY loads beep_cnt=BEEP_TICKS. beep=1 while beep_cnt!=0, and beep_cnt decrements on tick. A new eat_pulse retriggers (reloads) the count. eat_pulse outside PLAY is dropped.
  - beep_cnt is cleared on leaving PLAY, so no eat beep leaks into DYING or CLEAR.
  - In READY, OVER and IDLE, beep=0.
- Counter widths: sized by $clog2 of the largest *_TICKS. No wrap occurs, because the counter is reloaded on every entry.

Test Plan:
(Bench parameters: READY_TICKS=3, DEATH_TICKS=2, CLEAR_TICKS=16, BEEP_TICKS=2, LIVES=3, tick every 4 clk.)
1. Reset, then start pulse -> next edge state=1, lives=3, level=0, map_reload=1 and actor_rst_n=0 for exactly 1 clk; state=2 with run=1 after the 3rd tick.
2. In PLAY, assert crash -> state=3, run=0, beep=1 held; after 2 ticks state=1, lives=2, actor_rst_n pulses, map_reload stays 0.
3. Three deaths -> after the third DYING, lives=0, state=5, over=1; start -> state=1, lives=3, level=0, map_reload pulse.
4. crash and all_eaten high in the same PLAY cycle -> state=3 (not 4).
5. all_eaten in PLAY -> state=4, beep follows counter bit 3 (on for the first 8 ticks, then off); after 16 ticks level=1, state=1, map_reload and actor_rst_n pulse.
6. eat_pulse in PLAY -> beep=1 for 2 ticks; second eat_pulse mid-beep -> beep extended 2 ticks from the retrigger; eat_pulse in READY -> beep stays 0; rst low mid-DYING -> state=0, beep=0, lives=3.
